// File: rtl/demux_sched_pkg.sv
// Shared types and constants for the 1x8 demux scheduler slice.
package demux_sched_pkg;

    localparam int N_CH = 8;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/demux_sched_1x8_if.sv
// Stream-side bundle between the producer/consumers and the scheduler.
interface demux_sched_1x8_if
    import demux_sched_pkg::*;
#(
    parameter int DW = 8
);
    logic               mode;
    logic [N_CH-1:0]    chan_en;
    logic               in_valid;
    logic               in_ready;
    logic [DW-1:0]      in_data;
    logic [2:0]         in_dest;
    logic [2:0]         sel;
    logic [N_CH-1:0]    out_valid;
    logic [DW-1:0]      out_data;
    logic [N_CH-1:0]    out_ready;
    logic               drop;
    logic [7:0]         drop_cnt;
    logic               busy;

    // Environment side: producer, consumers and configuration.
    modport master (
        output mode, chan_en, in_valid, in_data, in_dest, out_ready,
        input  in_ready, sel, out_valid, out_data, drop, drop_cnt, busy
    );

    // Scheduler side.
    modport slave (
        input  mode, chan_en, in_valid, in_data, in_dest, out_ready,
        output in_ready, sel, out_valid, out_data, drop, drop_cnt, busy
    );
endinterface

// File: rtl/demux_1x8.sv
// Existing 1-to-8 demux datapath: routes input i to the output picked by sel.
module demux_1x8 (
    input  logic       i,
    input  logic [2:0] sel,
    output logic [7:0] y
);
    // Route the single input bit to the selected output; all others low.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        y      = '0;
        y[sel] = i;
    end
endmodule

// File: rtl/demux_sched_1x8_rr_pick8.sv
// Round-robin picker: first set mask bit strictly after ptr, wrapping 7->0.
module rr_pick8 (
    input  logic [7:0] mask,
    input  logic [2:0] ptr,
    output logic [2:0] idx,
    output logic       found
);
    // Walk the eight positions ptr+1 .. ptr+8 (mod 8); the 3-bit sum wraps on its own.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (!found && mask[3'(ptr + 3'(k))]) begin
                found = 1'b1;
                idx   = 3'(ptr + 3'(k));
            end
        end
    end
endmodule

// File: rtl/demux_sched_1x8.sv
// Scheduler for a 1x8 demux: accepts one word, steers it to a DIRECT or
// round-robin SCAN target, holds it until accepted or timed out.
module demux_sched_1x8
    import demux_sched_pkg::*;
#(
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    demux_sched_1x8_if.slave   bus
);
    localparam int WCW = $clog2(TIMEOUT + 1);

    state_t          state_q, state_d;
    logic [2:0]      sel_q;
    logic [2:0]      rr_ptr_q;
    logic [DW-1:0]   data_q;
    logic            mode_q;
    logic [WCW-1:0]  wait_q;
    logic            drop_q;
    logic [7:0]      drop_cnt_q;

    logic [2:0]      pick_idx;
    logic            pick_found;
    logic [2:0]      target;
    logic            legal;
    logic            capture;
    logic            deliver;
    logic            drop_d;

    rr_pick8 u_pick (
        .mask  (bus.chan_en),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Target and its legality are judged against the inputs present at the handshake.
    assign target = (bus.mode == MODE_DIRECT) ? bus.in_dest : pick_idx;
    assign legal  = (bus.mode == MODE_DIRECT) ? bus.chan_en[bus.in_dest] : pick_found;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            state_q <= state_d;
        end
    end

    // Next state plus the capture / delivery / drop decisions for this cycle.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        deliver = 1'b0;
        drop_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (legal) begin
                        capture = 1'b1;
                        state_d = SEND;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
            end
            SEND: begin
                if (bus.out_ready[sel_q]) begin
                    deliver = 1'b1;
                    state_d = IDLE;
                end else if (wait_q == WCW'(TIMEOUT - 1)) begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Held word, its target, wait counter, round-robin pointer and drop bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q      <= '0;
            rr_ptr_q   <= 3'd7;
            data_q     <= '0;
            mode_q     <= MODE_DIRECT;
            wait_q     <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (capture) begin
                data_q <= bus.in_data;
                sel_q  <= target;
                mode_q <= bus.mode;
                wait_q <= '0;
            end else if (state_q == SEND) begin
                wait_q <= wait_q + WCW'(1);
            end
            // Only words captured in SCAN mode advance the round-robin pointer.
            if (deliver && mode_q == MODE_SCAN) begin
                rr_ptr_q <= sel_q;
            end
            drop_q <= drop_d;
            if (drop_d && drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    demux_1x8 u_demux (
        .i   (state_q == SEND),
        .sel (sel_q),
        .y   (bus.out_valid)
    );

    assign bus.in_ready = (state_q == IDLE);
    assign bus.busy     = (state_q == SEND);
    assign bus.sel      = sel_q;
    assign bus.out_data = data_q;
    assign bus.drop     = drop_q;
    assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_sched_1x8.sv
// Self-checking bench for demux_sched_1x8 against a transaction-level model.
module tb_demux_sched_1x8;
    import demux_sched_pkg::*;

    localparam int DW      = 8;
    localparam int TIMEOUT = 15;

    logic clk;
    logic rst_n;

    demux_sched_1x8_if #(.DW(DW)) bus ();

    demux_sched_1x8 #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: last SCAN-delivered channel and saturating drop total.
    int model_rr   = 7;
    int model_drop = 0;

    function automatic void model_pick(input logic m, input logic [7:0] en, input logic [2:0] dest,
                                       output logic legal, output logic [2:0] tgt);
        legal = 1'b0;
        tgt   = 3'd0;
        if (m == MODE_DIRECT) begin
            legal = en[dest];
            tgt   = dest;
        end else begin
            for (int k = 1; k <= 8; k++) begin
                int c;
                c = (model_rr + k) % 8;
                if (!legal && en[c]) begin
                    legal = 1'b1;
                    tgt   = 3'(c);
                end
            end
        end
    endfunction

    function automatic void model_add_drop();
        if (model_drop < 255) model_drop++;
    endfunction

    // Present one word (assumes IDLE), follow it to delivery/timeout/drop, check every step.
    task automatic run_word(input logic m, input logic [7:0] en, input logic [2:0] dest,
                            input logic [DW-1:0] data, input logic [7:0] rdy, input string tag,
                            output logic [2:0] got_sel);
        logic       legal;
        logic [2:0] tgt;
        int         held;
        int         exp_held;
        bit         unstable;
        model_pick(m, en, dest, legal, tgt);
        bus.mode      = m;
        bus.chan_en   = en;
        bus.in_dest   = dest;
        bus.in_data   = data;
        bus.out_ready = rdy;
        bus.in_valid  = 1'b1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_ready: in_ready=%b expected 1", tag, bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        got_sel = bus.sel;
        if (!legal) begin
            model_add_drop();
            n_tests++;
            if (bus.drop !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 8'h00 ||
                bus.drop_cnt !== 8'(model_drop) || bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s illegal: drop=%b busy=%b out_valid=%h drop_cnt=%0d in_ready=%b expected 1 0 00 %0d 1",
                         tag, bus.drop, bus.busy, bus.out_valid, bus.drop_cnt, bus.in_ready, model_drop);
            end
        end else begin
            n_tests++;
            if (bus.out_valid !== (8'b1 << tgt) || bus.sel !== tgt || bus.out_data !== data ||
                bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.drop !== 1'b0) begin
                n_fail++;
                $display("FAIL %s capture: out_valid=%h sel=%0d out_data=%h busy=%b in_ready=%b drop=%b expected %h %0d %h 1 0 0",
                         tag, bus.out_valid, bus.sel, bus.out_data, bus.busy, bus.in_ready, bus.drop,
                         8'b1 << tgt, tgt, data);
            end
            held     = 0;
            unstable = 1'b0;
            while (bus.busy === 1'b1 && held < 100) begin
                if (bus.sel !== tgt || bus.out_valid !== (8'b1 << tgt)) unstable = 1'b1;
                held++;
                @(posedge clk); #1;
            end
            exp_held = rdy[tgt] ? 1 : TIMEOUT;
            if (!rdy[tgt]) model_add_drop();
            else if (m == MODE_SCAN) model_rr = int'(tgt);
            n_tests++;
            if (held != exp_held || unstable) begin
                n_fail++;
                $display("FAIL %s hold: held=%0d cycles unstable=%b expected %0d cycles stable",
                         tag, held, unstable, exp_held);
            end
            n_tests++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 8'h00 ||
                bus.drop !== !rdy[tgt] || bus.drop_cnt !== 8'(model_drop)) begin
                n_fail++;
                $display("FAIL %s end: in_ready=%b out_valid=%h drop=%b drop_cnt=%0d expected 1 00 %b %0d",
                         tag, bus.in_ready, bus.out_valid, bus.drop, bus.drop_cnt, !rdy[tgt], model_drop);
            end
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 8'h00 || bus.sel !== 3'd0 ||
            bus.out_data !== 8'h00 || bus.drop !== 1'b0 || bus.drop_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL reset: in_ready=%b busy=%b out_valid=%h sel=%0d out_data=%h drop=%b drop_cnt=%0d expected 1 0 00 0 00 0 0",
                     bus.in_ready, bus.busy, bus.out_valid, bus.sel, bus.out_data, bus.drop, bus.drop_cnt);
        end
    endtask

    task automatic test_direct();
        logic [2:0] s;
        run_word(MODE_DIRECT, 8'hFF, 3'd5, 8'hA5, 8'hFF, "direct", s);
        n_tests++;
        if (s !== 3'd5) begin
            n_fail++;
            $display("FAIL direct_sel: sel=%0d expected 5", s);
        end
    endtask

    task automatic test_scan();
        logic [2:0] s;
        logic [2:0] exp_seq [4];
        exp_seq = '{3'd1, 3'd4, 3'd7, 3'd1};
        for (int i = 0; i < 4; i++) begin
            run_word(MODE_SCAN, 8'b1001_0010, 3'd0, 8'(i + 8'h30), 8'hFF, "scan", s);
            n_tests++;
            if (s !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL scan_seq[%0d]: sel=%0d expected %0d", i, s, exp_seq[i]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [2:0] s;
        run_word(MODE_DIRECT, 8'hFF, 3'd3, 8'h5C, 8'hF7, "timeout", s);
    endtask

    task automatic test_illegal();
        logic [2:0] s;
        run_word(MODE_DIRECT, 8'hFB, 3'd2, 8'h11, 8'hFF, "illegal_direct", s);
        run_word(MODE_SCAN, 8'h00, 3'd0, 8'h22, 8'hFF, "illegal_scan", s);
    endtask

    task automatic test_mid_send();
        logic [2:0] s;
        // DIRECT capture, then disturb mode/enables while held.
        bus.mode = MODE_DIRECT; bus.chan_en = 8'hFF; bus.in_dest = 3'd6;
        bus.in_data = 8'h66; bus.out_ready = 8'h00; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.mode = MODE_SCAN; bus.chan_en = 8'h00; bus.out_ready = 8'h40;
        n_tests++;
        if (bus.out_valid !== 8'h40 || bus.sel !== 3'd6 || bus.out_data !== 8'h66) begin
            n_fail++;
            $display("FAIL mid_hold: out_valid=%h sel=%0d out_data=%h expected 40 6 66", bus.out_valid, bus.sel, bus.out_data);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.drop !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_deliver: busy=%b drop=%b in_ready=%b expected 0 0 1", bus.busy, bus.drop, bus.in_ready);
        end
        // SCAN capture of channel 0, then switch to DIRECT while held.
        model_pick(MODE_SCAN, 8'h01, 3'd0, s[0], s);
        bus.mode = MODE_SCAN; bus.chan_en = 8'h01; bus.in_data = 8'h77; bus.out_ready = 8'h00; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.mode = MODE_DIRECT; bus.chan_en = 8'h00; bus.in_dest = 3'd3; bus.out_ready = 8'h01;
        n_tests++;
        if (bus.sel !== 3'd0 || bus.out_valid !== 8'h01) begin
            n_fail++;
            $display("FAIL mid_scan_hold: sel=%0d out_valid=%h expected 0 01", bus.sel, bus.out_valid);
        end
        @(posedge clk); #1;
        model_rr = 0;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.drop !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_scan_deliver: busy=%b drop=%b expected 0 0", bus.busy, bus.drop);
        end
        run_word(MODE_SCAN, 8'hFF, 3'd0, 8'h88, 8'hFF, "mid_rr_next", s);
        n_tests++;
        if (s !== 3'd1) begin
            n_fail++;
            $display("FAIL mid_rr_next: sel=%0d expected 1", s);
        end
    endtask

    task automatic test_random();
        logic [2:0] s;
        logic [7:0] en;
        logic [7:0] rdy;
        for (int i = 0; i < 30; i++) begin
            en  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            rdy = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
            run_word(1'($urandom), en, 3'($urandom), 8'($urandom), rdy, "random", s);
        end
    endtask

    task automatic test_saturation();
        bus.mode = MODE_DIRECT; bus.chan_en = 8'h00; bus.in_dest = 3'd4; bus.in_valid = 1'b1;
        for (int i = 0; i < 260; i++) begin
            @(posedge clk);
            model_add_drop();
        end
        #1;
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.drop_cnt !== 8'(model_drop) || model_drop != 255 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL saturation: drop_cnt=%0d busy=%b expected 255 0", bus.drop_cnt, bus.busy);
        end
    endtask

    task automatic test_async_reset();
        logic [2:0] s;
        bus.mode = MODE_DIRECT; bus.chan_en = 8'hFF; bus.in_dest = 3'd4;
        bus.in_data = 8'h99; bus.out_ready = 8'h00; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.out_valid !== 8'h00 || bus.busy !== 1'b0 || bus.drop_cnt !== 8'h00 ||
            bus.drop !== 1'b0 || bus.sel !== 3'd0 || bus.out_data !== 8'h00 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: out_valid=%h busy=%b drop_cnt=%0d drop=%b sel=%0d out_data=%h in_ready=%b expected 00 0 0 0 0 00 1",
                     bus.out_valid, bus.busy, bus.drop_cnt, bus.drop, bus.sel, bus.out_data, bus.in_ready);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        model_rr   = 7;
        model_drop = 0;
        @(posedge clk); #1;
        n_tests++;
        if (bus.drop !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_drop: drop=%b expected 0", bus.drop);
        end
        run_word(MODE_SCAN, 8'hFF, 3'd0, 8'h42, 8'hFF, "post_reset", s);
        n_tests++;
        if (s !== 3'd0) begin
            n_fail++;
            $display("FAIL post_reset_pick: sel=%0d expected 0", s);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        bus.mode      = MODE_DIRECT;
        bus.chan_en   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_dest   = 3'd0;
        bus.out_ready = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_direct();
        test_scan();
        test_timeout();
        test_illegal();
        test_mid_send();
        test_random();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_sched_1x8.md
# demux_sched_1x8

Scheduler that sequences a 1-to-8 demultiplexer for a valid/ready data stream. Each accepted word is steered to one of eight output channels. The target is either supplied with the word (DIRECT) or chosen round-robin over enabled channels (SCAN). The block holds the word until the target channel accepts it, or drops it after a timeout. It sits between a single upstream producer and eight downstream consumers, and drives the select lines of the existing demux_1x8 datapath.

## Interface
- DW, 8, data word width
- TIMEOUT, 15, max cycles out_valid is held per word (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- mode  in  1  0 = DIRECT, 1 = SCAN; sampled at input handshake
- chan_en  in  8  channel enable mask; sampled at input handshake
- in_valid  in  1  upstream word valid
- in_ready  out  1  upstream may transfer
- in_data  in  DW  upstream word
- in_dest  in  3  target channel (DIRECT only)
- sel  out  3  demux select {s2,s1,s0} = current target
- out_valid  out  8  one-hot valid to target channel
- out_data  out  DW  held word, common to all channels
- out_ready  in  8  per-channel accept
- drop  out  1  one-cycle pulse: word discarded
- drop_cnt  out  8  saturating count of drops
- busy  out  1  high while a word is held

## Operation
- FSM with two states:
  - IDLE: in_ready=1.
  - SEND: in_ready=0, out_valid[sel]=1.
- IDLE→SEND on in_valid&in_ready, with a legal target. On this edge:
  - latch in_data and the target;
  - clear wait_cnt.
- Target selection in DIRECT mode: target = in_dest. The target is illegal if chan_en[in_dest]=0.
- Target selection in SCAN mode: target = first set bit of chan_en, searching from rr_ptr+1 upward with wrap 7→0. The target is illegal if chan_en=0.
- Illegal target: the word is consumed (handshake completes) and the FSM stays in IDLE. drop pulses and drop_cnt increments.
- SEND→IDLE on out_ready[sel]=1 (delivery).
  - In SCAN mode, rr_ptr←sel.
  - In DIRECT mode, rr_ptr is unchanged.
- SEND without out_ready[sel]: wait_cnt++. When wait_cnt=TIMEOUT-1 and no ready, go SEND→IDLE; drop pulses and drop_cnt increments.
- out_ready on non-target channels is ignored.
- Changes to mode or chan_en during SEND have no effect on the held word.
- drop_cnt saturates at 255.
- busy = (state==SEND).

## Timing
- Reset values:
  - state=IDLE, in_ready=1 (combinational from state);
  - sel=0, out_valid=0, out_data=0;
  - drop=0, drop_cnt=0, busy=0;
  - rr_ptr=7, so the first SCAN pick is the lowest enabled channel from 0.
- Latency: out_valid is high in the cycle after the input handshake.
- Throughput: at most one word per 2 cycles. in_ready is low in the delivery cycle and returns high the following cycle.
- Timeout bound: out_valid is held for exactly TIMEOUT cycles if never accepted.
- drop is registered, high the cycle after the drop decision.
- sel is stable for the whole SEND period and changes only on a capture edge.
- rst_n asserted mid-SEND: the word is lost, all outputs go to reset values immediately, and there is no drop pulse.

## Structure
- Package demux_sched_pkg holds:
  - state enum {IDLE, SEND};
  - mode constants MODE_DIRECT=0, MODE_SCAN=1;
  - the channel count constant 8.
- Sub-module rr_pick8 (combinational): inputs mask[7:0] and ptr[2:0]; outputs idx[2:0] and found.
- out_valid is generated by the existing demux_1x8: input i = (state==SEND), selects = sel.

## Test plan
- DIRECT, chan_en=FF, in_dest=5, out_ready=FF, data 0xA5 → out_valid=0x20, sel=5, out_data=A5 the next cycle; in_ready high again 2 cycles after the handshake.
- SCAN, chan_en=0b10010010, out_ready=FF, 4 words → targets 1,4,7,1.
- DIRECT, in_dest=3, out_ready[3]=0, TIMEOUT=15 → out_valid=0x08 for 15 cycles, then drop pulse, drop_cnt=1, in_ready=1.
- DIRECT, chan_en[2]=0, in_dest=2 → handshake completes, no out_valid, drop pulse, FSM stays IDLE; SCAN with chan_en=0 → same result.
- Mid-SEND: toggle mode and clear chan_en, assert out_ready[6] only → delivery on the held target 6; rr_ptr follows the capture-time mode.
- Assert rst_n low mid-SEND → out_valid=0, busy=0 asynchronously, drop_cnt=0, next SCAN pick starts from channel 0.
